// File: rtl/rdysetgo_test_pkg.sv
// Shared definitions for the Ready/Set/Go banner: sequencer state encoding and
// active-low 7-segment glyphs (vector MSB = segment a, LSB = segment g).
package rdysetgo_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RDY  = 2'd1,
        ST_SET  = 2'd2,
        ST_GO   = 2'd3
    } state_t;

    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_R     = 7'b1111010;
    localparam glyph_t GLYPH_D     = 7'b1000010;
    localparam glyph_t GLYPH_Y     = 7'b1000100;
    localparam glyph_t GLYPH_S     = 7'b0100100;
    localparam glyph_t GLYPH_E     = 7'b0110000;
    localparam glyph_t GLYPH_T     = 7'b1110000;
    localparam glyph_t GLYPH_G     = 7'b0100001;
    localparam glyph_t GLYPH_O     = 7'b1100010;
    localparam glyph_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/rdysetgo_test_seven_seg_scan.sv
// Four-digit multiplexed 7-segment scanner: free-running refresh counter and
// digit index, with registered active-low anode and segment outputs.
module seven_seg_scan
    import rdysetgo_test_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  glyph_t     d3,
    input  glyph_t     d2,
    input  glyph_t     d1,
    input  glyph_t     d0,
    input  logic       blank_all,
    output logic [3:0] an,
    output glyph_t     seg
);

    localparam int            RW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] RLAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic [3:0]    an_sel;
    glyph_t        digit_sel;

    always_comb begin
        an_sel      = 4'b1111;
        an_sel[idx] = 1'b0;
        digit_sel   = GLYPH_BLANK;
        case (idx)
            2'd3:    digit_sel = d3;
            2'd2:    digit_sel = d2;
            2'd1:    digit_sel = d1;
            default: digit_sel = d0;
        endcase
    end

    // Scan keeps running while blanked so the digit phase never restarts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt <= '0;
            idx  <= 2'd3;
            an   <= 4'b1111;
            seg  <= GLYPH_BLANK;
        end else begin
            if (rcnt == RLAST) begin
                rcnt <= '0;
                idx  <= idx - 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            an  <= blank_all ? 4'b1111 : an_sel;
            seg <= blank_all ? GLYPH_BLANK : digit_sel;
        end
    end

endmodule

// File: rtl/rdysetgo_test.sv
// Ready/Set/Go countdown banner sequencer driving a 4-digit 7-segment display.
// Optional RDYSETGO_AUTOCLEAR_EN: GO times out back to IDLE instead of holding.
//
// state | meaning
// IDLE  | display dark, waiting for Go while armed
// RDY   | showing "rdy" for WORD_CYCLES clocks
// SET   | showing "SEt" for WORD_CYCLES clocks
// GO    | showing "Go" (terminal unless autoclear is built in)
module rdysetgo_test
    import rdysetgo_test_pkg::*;
#(
    parameter int WORD_CYCLES    = 100_000_000,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Go,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int            WW    = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WORD_CYCLES - 1);

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          armed, armed_nxt;
    logic          wlast;
    glyph_t        d3, d2, d1, d0;

    assign wlast = (wcnt == WLAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            armed <= 1'b1;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            armed <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = '0;
        armed_nxt = armed;
        d3 = GLYPH_BLANK;
        d2 = GLYPH_BLANK;
        d1 = GLYPH_BLANK;
        d0 = GLYPH_BLANK;

        if (state != ST_IDLE)
            wcnt_nxt = wlast ? '0 : wcnt + WW'(1);

        case (state)
            ST_IDLE: begin
                if (Go && armed) begin
                    state_nxt = ST_RDY;
                    armed_nxt = 1'b0;
                end else if (!Go) begin
                    armed_nxt = 1'b1;
                end
            end
            ST_RDY: begin
                d3 = GLYPH_R;
                d2 = GLYPH_D;
                d1 = GLYPH_Y;
                if (wlast) state_nxt = ST_SET;
            end
            ST_SET: begin
                d3 = GLYPH_S;
                d2 = GLYPH_E;
                d1 = GLYPH_T;
                if (wlast) state_nxt = ST_GO;
            end
            default: begin
                d3 = GLYPH_G;
                d2 = GLYPH_O;
`ifdef RDYSETGO_AUTOCLEAR_EN
                if (wlast) state_nxt = ST_IDLE;
`else
                state_nxt = ST_GO;
`endif
            end
        endcase
    end

    seven_seg_scan #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .blank_all (state == ST_IDLE),
        .an        (an),
        .seg       (seg)
    );

endmodule

// File: tb/tb_rdysetgo_test.sv
// Scoreboard bench for rdysetgo_test: a time-based reference model predicts the
// display after every clock edge; a monitor compares the registered outputs.
module tb_rdysetgo_test;

    localparam int W = 20;
    localparam int R = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } disp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Go = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;

    disp_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_cyc = 0;

    // Reference model: edges since last reset, sequence start edge, armed flag.
    int    k = 0;
    int    start_k = 0;
    bit    active = 1'b0;
    bit    armed = 1'b1;

    rdysetgo_test #(
        .WORD_CYCLES(W),
        .REFRESH_CYCLES(R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Go    (Go),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int w, input int d);
        logic [6:0] g;
        g = 7'b1111111;
        case (w)
            0: case (d) 3: g = 7'b1111010; 2: g = 7'b1000010; 1: g = 7'b1000100; default: ; endcase
            1: case (d) 3: g = 7'b0100100; 2: g = 7'b0110000; 1: g = 7'b1110000; default: ; endcase
            default: case (d) 3: g = 7'b0100001; 2: g = 7'b1100010; default: ; endcase
        endcase
        return g;
    endfunction

    // Expected display after the coming edge, from the model as it stands before it.
    function automatic disp_t predict(input bit rst_n);
        disp_t e;
        int    idx;
        int    w;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        if (rst_n && active) begin
            idx   = 3 - ((k / R) % 4);
            w     = (k - start_k) / W;
            if (w > 2) w = 2;
            e.an  = ~(4'b0001 << idx);
            e.seg = glyph(w, idx);
        end
        return e;
    endfunction

    task automatic step(input bit rst_n, input bit go);
        @(negedge clk);
        reset = rst_n;
        Go    = go;
        exp_q.push_back(predict(rst_n));
        if (!rst_n) begin
            k      = 0;
            active = 1'b0;
            armed  = 1'b1;
        end else begin
            if (!active) begin
                if (go && armed) begin
                    active  = 1'b1;
                    start_k = k + 1;
                    armed   = 1'b0;
                end else if (!go) begin
                    armed = 1'b1;
                end
            end
            k++;
`ifdef RDYSETGO_AUTOCLEAR_EN
            if (active && (k - start_k) >= 3 * W) active = 1'b0;
`endif
        end
    endtask

    initial begin : monitor
        disp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (an !== e.an || seg !== e.seg) begin
                    n_bad++;
                    $display("FAIL disp cyc=%0d an got=%b exp=%b seg got=%b exp=%b",
                             n_cyc, an, e.an, seg, e.seg);
                end
            end
        end
    end

    initial begin : driver
        // Reset with Go high; Go must not leak through.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // Go held: rdy, SEt, Go; with autoclear it times out and stays dark.
        for (int i = 0; i < 5 * W; i++) step(1'b1, 1'b1);
        // Drop Go for one cycle then raise it to restart (autoclear build).
        step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        // Go toggling while the sequence runs or holds.
        for (int i = 0; i < 1000; i++) step(1'b1, 1'($urandom_range(0, 1)));
        // Fresh start, then a one-edge reset mid-SET.
        step(1'b0, 1'b0);
        for (int i = 0; i < W + 10; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++)
            step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0));
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
